// File: rtl/load_access_unit.sv
// Multi-cycle MEM-stage load path: address check, one bus word read with
// wait states and timeout, lane extraction and sign/zero extension.
module load_access_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] DM_END = 16'h2fff,
  parameter logic [ADDR_W-1:0] DEV0_BASE = 16'h7f00,
  parameter logic [ADDR_W-1:0] DEV0_END = 16'h7f0b,
  parameter logic [ADDR_W-1:0] DEV1_BASE = 16'h7f10,
  parameter logic [ADDR_W-1:0] DEV1_END = 16'h7f1b,
  parameter logic [ADDR_W-1:0] DEV2_BASE = 16'h7f20,
  parameter logic [ADDR_W-1:0] DEV2_END = 16'h7f23,
  parameter logic [ADDR_W-1:0] WORD_ONLY = 16'h7f00,
  parameter int TIMEOUT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [2:0]        i_req_op,
  input  logic              i_req_ovf,
  output logic              o_bus_rd_req,
  output logic [ADDR_W-1:0] o_bus_addr,
  input  logic              i_bus_rd_ack,
  input  logic [31:0]       i_bus_rdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_data,
  output logic              o_rsp_exc_adel
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LB  = 3'd4;
  localparam logic [2:0] OP_LBU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_op;
  logic [1:0]        r_lane;
  logic [ADDR_W-3:0] r_waddr;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_data;
  logic              r_exc;

  logic        w_op_ok;
  logic        w_accept;
  logic        w_misalign;
  logic        w_in_range;
  logic        w_word_viol;
  logic        w_exc;
  logic        w_timeout;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ext;

  assign w_op_ok = (i_req_op >= OP_LW) && (i_req_op <= OP_LBU);
  assign w_accept = i_req_valid & o_req_ready & w_op_ok & ~i_flush;

  assign w_misalign =
    ((i_req_op == OP_LW) && (i_req_addr[1:0] != 2'b00)) ||
    (((i_req_op == OP_LH) || (i_req_op == OP_LHU)) && i_req_addr[0]);

  assign w_in_range =
    (i_req_addr <= DM_END) ||
    ((i_req_addr >= DEV0_BASE) && (i_req_addr <= DEV0_END)) ||
    ((i_req_addr >= DEV1_BASE) && (i_req_addr <= DEV1_END)) ||
    ((i_req_addr >= DEV2_BASE) && (i_req_addr <= DEV2_END));

  assign w_word_viol = (i_req_op != OP_LW) && (i_req_addr >= WORD_ONLY);
  assign w_exc = w_misalign | ~w_in_range | w_word_viol | i_req_ovf;

  // ack in the last wait cycle still wins over the timeout
  assign w_timeout = (r_cnt == CNT_LAST) & ~i_bus_rd_ack;

  always_comb begin
    w_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (r_lane)
      2'd0:    w_byte = i_bus_rdata[7:0];
      2'd1:    w_byte = i_bus_rdata[15:8];
      2'd2:    w_byte = i_bus_rdata[23:16];
      default: w_byte = i_bus_rdata[31:24];
    endcase
    case (r_op)
      OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ext = {16'h0000, w_half};
      OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ext = {24'h000000, w_byte};
      default: w_ext = i_bus_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_exc ? S_RESP : S_WAIT;
        S_WAIT: if (i_bus_rd_ack || w_timeout) w_next = S_RESP;
        S_RESP: if (i_rsp_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op    <= 3'd0;
      r_lane  <= 2'd0;
      r_waddr <= '0;
      r_cnt   <= '0;
      r_data  <= 32'd0;
      r_exc   <= 1'b0;
    end else if (!i_flush) begin
      if (r_state == S_IDLE && w_accept) begin
        r_op    <= i_req_op;
        r_lane  <= i_req_addr[1:0];
        r_waddr <= i_req_addr[ADDR_W-1:2];
        r_cnt   <= '0;
        r_data  <= 32'd0;
        r_exc   <= w_exc;
      end else if (r_state == S_WAIT) begin
        if (i_bus_rd_ack) begin
          r_data <= w_ext;
          r_exc  <= 1'b0;
        end else if (w_timeout) begin
          r_data <= 32'd0;
          r_exc  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_req_ready    = (r_state == S_IDLE) & ~i_reset;
    o_bus_rd_req   = (r_state == S_WAIT);
    o_bus_addr     = {r_waddr, 2'b00};
    o_rsp_valid    = (r_state == S_RESP);
    o_rsp_data     = (r_state == S_RESP) ? r_data : 32'd0;
    o_rsp_exc_adel = (r_state == S_RESP) & r_exc;
  end

endmodule

// File: tb/tb_load_access_unit.sv
// Scoreboard bench for load_access_unit: directed loads push expected
// responses; a monitor pops them on every response handshake.
module tb_load_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0;
  logic [2:0]  req_op = 3'd0;
  logic        req_ovf = 1'b0;
  logic        bus_rd_req;
  logic [15:0] bus_addr;
  logic        bus_rd_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_exc_adel;

  int n_chk = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];

  localparam logic [2:0] LW = 3'd1, LH = 3'd2, LHU = 3'd3;
  localparam logic [2:0] LB = 3'd4, LBU = 3'd5;

  load_access_unit dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_flush(flush),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_addr(req_addr),
    .i_req_op(req_op),
    .i_req_ovf(req_ovf),
    .o_bus_rd_req(bus_rd_req),
    .o_bus_addr(bus_addr),
    .i_bus_rd_ack(bus_rd_ack),
    .i_bus_rdata(bus_rdata),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data),
    .o_rsp_exc_adel(rsp_exc_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      logic [32:0] e;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rsp_data", rsp_data, e[31:0]);
        chk("sb_rsp_exc", {31'd0, rsp_exc_adel}, {31'd0, e[32]});
      end
    end
  end

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  // n_ack = 0: exception expected; else ack on that WAIT cycle
  task automatic load(input logic [2:0] op, input logic [15:0] addr,
                      input logic ovf, input int n_ack,
                      input logic [31:0] rdata, input int hold,
                      input logic [31:0] exp_data);
    exp_q.push_back({(n_ack == 0), exp_data});
    req_op = op;
    req_addr = addr;
    req_ovf = ovf;
    req_valid = 1'b1;
    adv();
    req_valid = 1'b0;
    req_ovf = 1'b0;
    if (n_ack == 0) begin
      chk("exc_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("exc_flag", {31'd0, rsp_exc_adel}, 32'd1);
      chk("exc_no_bus", {31'd0, bus_rd_req}, 32'd0);
    end else begin
      chk("bus_rd_req", {31'd0, bus_rd_req}, 32'd1);
      chk("bus_addr", {16'd0, bus_addr}, {16'd0, addr[15:2], 2'b00});
      repeat (n_ack - 1) adv();
      bus_rd_ack = 1'b1;
      bus_rdata = rdata;
      if (hold > 0) rsp_ready = 1'b0;
      adv();
      bus_rd_ack = 1'b0;
      chk("ld_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("ld_bus_drop", {31'd0, bus_rd_req}, 32'd0);
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_not_ready", {31'd0, req_ready}, 32'd0);
      adv();
    end
    rsp_ready = 1'b1;
    adv();
    chk("back_idle", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    adv();
    adv();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_bus_rd_req", {31'd0, bus_rd_req}, 32'd0);
    chk("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_exc", {31'd0, rsp_exc_adel}, 32'd0);
    reset = 1'b0;
    adv();
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    load(LB, 16'h1003, 1'b0, 2, 32'h80123456, 0, 32'hFFFFFF80);
    load(LHU, 16'h0002, 1'b0, 1, 32'hABCD1234, 0, 32'h0000ABCD);
    load(LH, 16'h0002, 1'b0, 1, 32'hABCD1234, 0, 32'hFFFFABCD);
    load(LH, 16'h0000, 1'b0, 2, 32'h00008001, 0, 32'hFFFF8001);
    load(LBU, 16'h0001, 1'b0, 1, 32'h0000F700, 0, 32'h000000F7);
    load(LB, 16'h2fff, 1'b0, 3, 32'h7F000000, 0, 32'h0000007F);
    load(LW, 16'h7f10, 1'b0, 1, 32'h01020304, 0, 32'h01020304);
    load(LW, 16'h7f20, 1'b0, 2, 32'hCAFEF00D, 0, 32'hCAFEF00D);

    load(LH, 16'h0001, 1'b0, 0, 32'h0, 0, 32'h0);
    load(LB, 16'h7f04, 1'b0, 0, 32'h0, 0, 32'h0);
    load(LW, 16'h3000, 1'b0, 0, 32'h0, 0, 32'h0);
    load(LW, 16'h7f0c, 1'b0, 0, 32'h0, 0, 32'h0);
    load(LW, 16'h0000, 1'b1, 0, 32'h0, 0, 32'h0);
    load(LW, 16'h7f24, 1'b0, 0, 32'h0, 0, 32'h0);

    load(LW, 16'h7f08, 1'b0, 4, 32'hDEADBEEF, 3, 32'hDEADBEEF);

    // timeout after 8 wait cycles, then a stray ack
    exp_q.push_back({1'b1, 32'h0});
    req_op = LW;
    req_addr = 16'h0010;
    req_valid = 1'b1;
    adv();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("to_bus_held", {31'd0, bus_rd_req}, 32'd1);
      chk("to_no_rsp", {31'd0, rsp_valid}, 32'd0);
      adv();
    end
    chk("to_last_wait", {31'd0, bus_rd_req}, 32'd1);
    adv();
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_exc", {31'd0, rsp_exc_adel}, 32'd1);
    chk("to_bus_drop", {31'd0, bus_rd_req}, 32'd0);
    adv();
    bus_rd_ack = 1'b1;
    bus_rdata = 32'h12345678;
    adv();
    bus_rd_ack = 1'b0;
    chk("stray_ack_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("stray_ack_bus", {31'd0, bus_rd_req}, 32'd0);

    // flush on the 2nd wait cycle
    req_op = LW;
    req_addr = 16'h0020;
    req_valid = 1'b1;
    adv();
    req_valid = 1'b0;
    adv();
    flush = 1'b1;
    adv();
    flush = 1'b0;
    chk("fl_bus", {31'd0, bus_rd_req}, 32'd0);
    chk("fl_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("fl_ready", {31'd0, req_ready}, 32'd1);
    bus_rd_ack = 1'b1;
    adv();
    bus_rd_ack = 1'b0;
    chk("fl_ack_rsp", {31'd0, rsp_valid}, 32'd0);
    adv();
    chk("fl_ack_rsp2", {31'd0, rsp_valid}, 32'd0);

    // reset pulse on the 2nd wait cycle
    req_valid = 1'b1;
    adv();
    req_valid = 1'b0;
    adv();
    reset = 1'b1;
    adv();
    reset = 1'b0;
    chk("rs_bus", {31'd0, bus_rd_req}, 32'd0);
    chk("rs_rsp", {31'd0, rsp_valid}, 32'd0);
    bus_rd_ack = 1'b1;
    adv();
    bus_rd_ack = 1'b0;
    chk("rs_ack_rsp", {31'd0, rsp_valid}, 32'd0);

    // request during flush and non-load op are not accepted
    req_op = LW;
    req_addr = 16'h0000;
    req_valid = 1'b1;
    flush = 1'b1;
    adv();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_req_bus", {31'd0, bus_rd_req}, 32'd0);
    chk("fl_req_rsp", {31'd0, rsp_valid}, 32'd0);
    req_op = 3'd0;
    req_valid = 1'b1;
    adv();
    req_valid = 1'b0;
    chk("op0_bus", {31'd0, bus_rd_req}, 32'd0);
    chk("op0_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("op0_ready", {31'd0, req_ready}, 32'd1);

    load(LBU, 16'h0003, 1'b0, 1, 32'hF1000000, 0, 32'h000000F1);

    adv();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
